// File: rtl/axi_lite_timer_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_timer_responder_pkg                                         |
// | Shared types and helpers for the AXI4-Lite machine timer responder:  |
// | response codes, register offsets, window size and byte-strobe merge. |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package axi_lite_timer_responder_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_t;

  typedef enum logic [4:0] {
    OFF_MTIME_LO = 5'h00,
    OFF_MTIME_HI = 5'h04,
    OFF_CMP_LO   = 5'h08,
    OFF_CMP_HI   = 5'h0C,
    OFF_SCRATCH  = 5'h10,
    OFF_CTRL     = 5'h14
  } timer_reg_offset_t;

  localparam int TIMER_WINDOW_BYTES = 32;

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_timer_responder_mtime_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mtime_counter                                                        |
// | 64-bit machine time counter. A write replaces one 32-bit half and    |
// | suppresses that cycle's increment (no carry into the other half).    |
// | Optional prescaler selected by macro AXI_TIMER_PRESCALE_EN.          |
// | Ports: clk, rst_n (async, active low), i_en (prescale build only),   |
// |        i_wr_lo/i_wr_hi/i_wdata half writes, o_mtime, o_tick.         |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mtime_counter #(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef AXI_TIMER_PRESCALE_EN
  input  logic        i_en,
`endif
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_mtime,
  output logic        o_tick
);

  logic [63:0] r_mtime;
  logic        w_tick;

`ifdef AXI_TIMER_PRESCALE_EN
  localparam int c_presc = (PRESCALE < 1) ? 1 : PRESCALE;
  localparam int c_cnt_w = $clog2(c_presc) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(c_presc - 1);

  logic [c_cnt_w-1:0] r_cnt;

  // Counter is held at zero while disabled or on an mtime write so the
  // first tick after either event is a full PRESCALE period away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || i_wr_lo || i_wr_hi || (r_cnt == c_cnt_max)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  assign w_tick = i_en & (r_cnt == c_cnt_max);
`else
  // Without the prescaler mtime advances every cycle; PRESCALE has no effect.
  if (PRESCALE >= 1) begin : g_tick_every_cycle
    assign w_tick = 1'b1;
  end else begin : g_tick_every_cycle_clamped
    assign w_tick = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime <= '0;
    end else if (i_wr_lo) begin
      r_mtime[31:0] <= i_wdata;
    end else if (i_wr_hi) begin
      r_mtime[63:32] <= i_wdata;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  assign o_mtime = r_mtime;
  assign o_tick  = w_tick;

endmodule
`default_nettype wire

// File: rtl/axi_lite_timer_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_timer_responder                                             |
// | AXI4-Lite subordinate holding mtime, mtimecmp, scratch and ctrl.en;  |
// | drives the registered machine timer interrupt.                      |
// | Ports: clk, rst_n (async, active low); AXI4-Lite AW/W/B/AR/R         |
// |        channels (s_*); timer_interrupt.                              |
// | Config macro: AXI_TIMER_PRESCALE_EN (mtime ticks every PRESCALE clk) |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module axi_lite_timer_responder
  import axi_lite_timer_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h6000_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        timer_interrupt
);

  localparam logic [31:0] c_win_mask = ~(32'(TIMER_WINDOW_BYTES) - 32'd1);

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[4:0] >= 5'h18) ||
           ((a & c_win_mask) != (BASE_ADDR & c_win_mask));
  endfunction

  logic        r_awready, r_wready, r_aw_held, r_w_held, r_bvalid;
  logic [31:0] r_awaddr, r_wdata;
  logic [3:0]  r_wstrb;
  axi_resp_t   r_bresp;
  logic        r_arready, r_rvalid;
  logic [31:0] r_rdata;
  axi_resp_t   r_rresp;
  logic [63:0] r_cmp;
  logic [31:0] r_scratch;
  logic        r_en;
  logic [31:0] r_snap_hi;
  logic        r_snap_valid;
  logic        r_irq;

  logic        w_aw_fire, w_w_fire, w_do_write, w_wr_err, w_wr_ok;
  logic [31:0] w_wr_addr, w_wr_data;
  logic [3:0]  w_wr_strb;
  logic [4:0]  w_wr_off, w_rd_off;
  logic        w_ar_fire, w_rd_err;
  logic [31:0] w_rd_data, w_mtime_wdata;
  logic [63:0] w_mtime;
  logic        w_tick_unused;

  assign w_aw_fire = s_awvalid & r_awready;
  assign w_w_fire  = s_wvalid & r_wready;
  // A channel arriving this cycle counts as held, so the register update
  // happens on the edge the second of AW/W is accepted.
  assign w_do_write = (r_aw_held | w_aw_fire) & (r_w_held | w_w_fire);
  assign w_wr_addr  = r_aw_held ? r_awaddr : s_awaddr;
  assign w_wr_data  = r_w_held ? r_wdata : s_wdata;
  assign w_wr_strb  = r_w_held ? r_wstrb : s_wstrb;
  assign w_wr_off   = w_wr_addr[4:0];
  assign w_wr_err   = addr_err(w_wr_addr);
  assign w_wr_ok    = w_do_write & ~w_wr_err;

  assign w_mtime_wdata = apply_wstrb((w_wr_off == OFF_MTIME_HI) ? w_mtime[63:32] : w_mtime[31:0],
                                     w_wr_data, w_wr_strb);

  mtime_counter #(.PRESCALE(PRESCALE)) u_mtime (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef AXI_TIMER_PRESCALE_EN
    .i_en    (r_en),
`endif
    .i_wr_lo (w_wr_ok && (w_wr_off == OFF_MTIME_LO)),
    .i_wr_hi (w_wr_ok && (w_wr_off == OFF_MTIME_HI)),
    .i_wdata (w_mtime_wdata),
    .o_mtime (w_mtime),
    .o_tick  (w_tick_unused)
  );

  // Write channel capture and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_do_write) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (w_aw_fire) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= s_awaddr;
        end
        if (w_w_fire) begin
          r_w_held <= 1'b1;
          r_wdata  <= s_wdata;
          r_wstrb  <= s_wstrb;
        end
      end
      if (w_aw_fire) r_awready <= 1'b0;
      if (w_w_fire)  r_wready  <= 1'b0;
      // Readies stay low until B completes: one write outstanding.
      if (r_bvalid && s_bready) begin
        r_bvalid  <= 1'b0;
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end
    end
  end

  // Register file (mtime lives in the counter).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp     <= '1;
      r_scratch <= '0;
      r_en      <= 1'b0;
    end else if (w_wr_ok) begin
      case (w_wr_off)
        OFF_CMP_LO:  r_cmp[31:0]  <= apply_wstrb(r_cmp[31:0], w_wr_data, w_wr_strb);
        OFF_CMP_HI:  r_cmp[63:32] <= apply_wstrb(r_cmp[63:32], w_wr_data, w_wr_strb);
        OFF_SCRATCH: r_scratch    <= apply_wstrb(r_scratch, w_wr_data, w_wr_strb);
        OFF_CTRL:    if (w_wr_strb[0]) r_en <= w_wr_data[0];
        default:     ;
      endcase
    end
  end

  assign w_ar_fire = s_arvalid & r_arready;
  assign w_rd_off  = s_araddr[4:0];
  assign w_rd_err  = addr_err(s_araddr);

  always_comb begin
    w_rd_data = '0;
    case (w_rd_off)
      OFF_MTIME_LO: w_rd_data = w_mtime[31:0];
      OFF_MTIME_HI: w_rd_data = r_snap_valid ? r_snap_hi : w_mtime[63:32];
      OFF_CMP_LO:   w_rd_data = r_cmp[31:0];
      OFF_CMP_HI:   w_rd_data = r_cmp[63:32];
      OFF_SCRATCH:  w_rd_data = r_scratch;
      OFF_CTRL:     w_rd_data = {31'd0, r_en};
      default:      w_rd_data = '0;
    endcase
  end

  // Read channel. A lo read latches hi so a following hi read is coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arready    <= 1'b1;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_rresp      <= RESP_OKAY;
      r_snap_hi    <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      if (w_ar_fire) begin
        r_arready <= 1'b0;
        r_rvalid  <= 1'b1;
        r_rdata   <= w_rd_err ? 32'd0 : w_rd_data;
        r_rresp   <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
        if (!w_rd_err && (w_rd_off == OFF_MTIME_LO)) begin
          r_snap_hi    <= w_mtime[63:32];
          r_snap_valid <= 1'b1;
        end
        if (!w_rd_err && (w_rd_off == OFF_MTIME_HI)) begin
          r_snap_valid <= 1'b0;
        end
      end
      if (r_rvalid && s_rready) begin
        r_rvalid  <= 1'b0;
        r_arready <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= r_en & (w_mtime >= r_cmp);
  end

  assign s_awready       = r_awready;
  assign s_wready        = r_wready;
  assign s_bvalid        = r_bvalid;
  assign s_bresp         = r_bresp;
  assign s_arready       = r_arready;
  assign s_rvalid        = r_rvalid;
  assign s_rdata         = r_rdata;
  assign s_rresp         = r_rresp;
  assign timer_interrupt = r_irq;

endmodule
`default_nettype wire
